// File: rtl/ddr4_cmd_sequencer_pkg.sv
// Shared types and constants for the DDR4 command sequencer: command/state enums,
// timing parameters, address bit positions and the command-to-address encoder.
package ddr4_cmd_sequencer_pkg;

    localparam int T_RCD  = 4;
    localparam int T_CL   = 4;
    localparam int T_WR   = 4;
    localparam int T_RP   = 4;
    localparam int T_RFC  = 16;
    localparam int T_REFI = 780;

    localparam logic [19:0] ADDR_NOP = 20'h1C000;
    localparam int A_RAS = 16;
    localparam int A_CAS = 15;
    localparam int A_WE  = 14;
    localparam int A_AP  = 10;

    typedef enum logic [2:0] {
        CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_PREA, CMD_REF
    } cmd_e;

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_PRE_W, S_ACT, S_ACT_W, S_RW, S_WR_W, S_RD_W,
        S_PREA, S_PREA_W, S_REF, S_REF_W
    } seq_state_e;

    typedef struct packed {
        logic        write;
        logic [2:0]  bank;   // {bg, bank}
        logic [16:0] row;
        logic [9:0]  col;
        logic [15:0] wdata;
    } req_t;

    // Control bits default to NOP (ras_n/cas_n/we_n high); each command pulls its own low.
    function automatic logic [19:0] cmd_addr(input cmd_e cmd, input logic [2:0] bank,
                                             input logic [16:0] row, input logic [9:0] col);
        logic [19:0] a;
        a = ADDR_NOP;
        case (cmd)
            CMD_ACT: a = {bank, row};
            CMD_RD: begin
                a[19:17] = bank;
                a[A_CAS] = 1'b0;
                a[9:0]   = col;
            end
            CMD_WR: begin
                a[19:17] = bank;
                a[A_CAS] = 1'b0;
                a[A_WE]  = 1'b0;
                a[9:0]   = col;
            end
            CMD_PRE: begin
                a[19:17] = bank;
                a[A_RAS] = 1'b0;
                a[A_WE]  = 1'b0;
            end
            CMD_PREA: begin
                a[A_RAS] = 1'b0;
                a[A_WE]  = 1'b0;
                a[A_AP]  = 1'b1;
            end
            default: a = ADDR_NOP;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/ddr4_bank_tracker.sv
// Open-row table for the 8 banks: lookup of the incoming request plus
// open/close updates driven by issued ACT / PRE / PREA commands.
module ddr4_bank_tracker (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  lkp_bank,
    input  logic [16:0] lkp_row,
    output logic        lkp_hit,
    output logic        lkp_closed,
    input  logic        set_open,
    input  logic        clr_one,
    input  logic        clr_all,
    input  logic [2:0]  upd_bank,
    input  logic [16:0] upd_row
);
    logic [7:0]       vld;
    logic [7:0][16:0] rows;

    assign lkp_closed = !vld[lkp_bank];
    assign lkp_hit    = vld[lkp_bank] && (rows[lkp_bank] == lkp_row);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld  <= '0;
            rows <= '0;
        end else if (clr_all) begin
            vld <= '0;
        end else if (set_open) begin
            vld[upd_bank]  <= 1'b1;
            rows[upd_bank] <= upd_row;
        end else if (clr_one) begin
            vld[upd_bank] <= 1'b0;
        end
    end
endmodule

// File: rtl/ddr4_cmd_sequencer.sv
// Host-request to DDR4 command sequencer: open-page row management per bank,
// periodic PREA+REF refresh, and read-data return after T_CL.
module ddr4_cmd_sequencer
    import ddr4_cmd_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_bg,
    input  logic [1:0]  req_bank,
    input  logic [16:0] req_row,
    input  logic [9:0]  req_col,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        act_n,
    output logic        refresh,
    output logic [19:0] addr,
    output logic [15:0] data_in,
    input  logic [15:0] data_out
);
    // Wait-state loads: counter runs down to 0, so a state lasting L cycles loads L-1.
    localparam logic [4:0]  W_RP     = 5'(T_RP - 2);
    localparam logic [4:0]  W_RCD    = 5'(T_RCD - 2);
    localparam logic [4:0]  W_WR     = 5'(T_WR - 2);
    localparam logic [4:0]  W_CL     = 5'(T_CL - 1);
    localparam logic [4:0]  W_RFC    = 5'(T_RFC - 2);
    localparam logic [9:0]  REFI_END = 10'(T_REFI - 1);

    seq_state_e  state, state_nx;
    cmd_e        cmd;
    req_t        req_q;
    logic [4:0]  wcnt, wcnt_nx;
    logic [9:0]  ref_cnt;
    logic        ref_pend;
    logic        rdy_en;
    logic [15:0] wdata_q;
    logic        hit, closed, accept;

    // rdy_en keeps req_ready low for the first cycle after reset release.
    assign req_ready = rdy_en && (state == S_IDLE) && !ref_pend;
    assign accept    = req_valid && req_ready;

    ddr4_bank_tracker u_banks (
        .clk        (clk),
        .reset      (reset),
        .lkp_bank   ({req_bg, req_bank}),
        .lkp_row    (req_row),
        .lkp_hit    (hit),
        .lkp_closed (closed),
        .set_open   (cmd == CMD_ACT),
        .clr_one    (cmd == CMD_PRE),
        .clr_all    (cmd == CMD_PREA),
        .upd_bank   (req_q.bank),
        .upd_row    (req_q.row)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wcnt     <= '0;
            req_q    <= '0;
            rdy_en   <= 1'b0;
            wdata_q  <= '0;
            ref_cnt  <= '0;
            ref_pend <= 1'b0;
        end else begin
            state  <= state_nx;
            wcnt   <= wcnt_nx;
            rdy_en <= 1'b1;
            if (accept)
                req_q <= '{req_write, {req_bg, req_bank}, req_row, req_col, req_wdata};
            if (cmd == CMD_WR)
                wdata_q <= req_q.wdata;
            if (ref_cnt == REFI_END) begin
                ref_cnt  <= '0;
                ref_pend <= 1'b1;
            end else begin
                ref_cnt <= ref_cnt + 10'd1;
                if (state == S_REF)
                    ref_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        wcnt_nx   = wcnt;
        cmd       = CMD_NOP;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (ref_pend)
                    state_nx = S_PREA;
                else if (accept)
                    state_nx = hit ? S_RW : (closed ? S_ACT : S_PRE);
            end
            S_PRE:    begin cmd = CMD_PRE;  state_nx = S_PRE_W;  wcnt_nx = W_RP;  end
            S_ACT:    begin cmd = CMD_ACT;  state_nx = S_ACT_W;  wcnt_nx = W_RCD; end
            S_PREA:   begin cmd = CMD_PREA; state_nx = S_PREA_W; wcnt_nx = W_RP;  end
            S_REF:    begin cmd = CMD_REF;  state_nx = S_REF_W;  wcnt_nx = W_RFC; end
            S_RW: begin
                cmd      = req_q.write ? CMD_WR : CMD_RD;
                state_nx = req_q.write ? S_WR_W : S_RD_W;
                wcnt_nx  = req_q.write ? W_WR : W_CL;
            end
            S_PRE_W, S_ACT_W, S_WR_W, S_RD_W, S_PREA_W, S_REF_W: begin
                if (wcnt != 5'd0) begin
                    wcnt_nx = wcnt - 5'd1;
                end else begin
                    rsp_valid = (state == S_RD_W);
                    case (state)
                        S_PRE_W:  state_nx = S_ACT;
                        S_ACT_W:  state_nx = S_RW;
                        S_PREA_W: state_nx = S_REF;
                        default:  state_nx = S_IDLE;
                    endcase
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign act_n     = (cmd != CMD_ACT);
    assign refresh   = (cmd == CMD_REF);
    assign addr      = cmd_addr(cmd, req_q.bank, req_q.row, req_q.col);
    assign data_in   = (cmd == CMD_WR) ? req_q.wdata : wdata_q;
    assign rsp_rdata = rsp_valid ? data_out : 16'h0000;
endmodule

// File: tb/tb_ddr4_cmd_sequencer.sv
// Scoreboard bench: each accepted request pushes its expected command/response
// events with their cycle numbers; a negedge monitor pops and compares them.
module tb_ddr4_cmd_sequencer;
    localparam logic [2:0] K_ACT = 3'd1, K_RD = 3'd2, K_WR = 3'd3, K_PRE = 3'd4,
                           K_PREA = 3'd5, K_REF = 3'd6, K_RSP = 3'd7;
    localparam logic [19:0] NOP = 20'h1C000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_bg;
    logic [1:0]  req_bank;
    logic [16:0] req_row;
    logic [9:0]  req_col;
    logic [15:0] req_wdata;
    logic        rsp_valid, act_n, refresh;
    logic [15:0] rsp_rdata, data_in, data_out;
    logic [19:0] addr;

    typedef struct { int cyc; logic [38:0] ev; } exp_t;
    exp_t        sb[$];
    int          cyc = 0;
    int          n_chk = 0, n_err = 0;
    int          rd_cyc = -1;
    logic [15:0] rd_dat = 16'h0;
    logic        mvld[8];
    logic [16:0] mrow[8];
    logic [38:0] got;
    bit          any;

    ddr4_cmd_sequencer dut (
        .clk(clk), .reset(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_bg(req_bg), .req_bank(req_bank), .req_row(req_row),
        .req_col(req_col), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .act_n(act_n), .refresh(refresh), .addr(addr), .data_in(data_in), .data_out(data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign data_out = (cyc == rd_cyc) ? rd_dat : 16'hdead;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [2:0] k, input logic [19:0] a, input logic [15:0] d);
        exp_t e;
        e.cyc = c;
        e.ev  = {k, a, d};
        sb.push_back(e);
    endtask

    task automatic observe(input logic [38:0] ev);
        exp_t e;
        if (sb.size() == 0) begin
            chk("unexpected_event", 64'(ev), 64'h0);
        end else begin
            e = sb.pop_front();
            chk("event_cycle", 64'(cyc), 64'(e.cyc));
            chk("event_value", 64'(ev), 64'(e.ev));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            any = 1'b1;
            got = '0;
            if (!act_n)
                got = {K_ACT, addr, 16'h0};
            else if (refresh)
                got = {K_REF, addr, 16'h0};
            else if (addr != NOP && !addr[15])
                got = addr[14] ? {K_RD, addr, 16'h0} : {K_WR, addr, data_in};
            else if (addr != NOP)
                got = {addr[10] ? K_PREA : K_PRE, addr, 16'h0};
            else
                any = 1'b0;
            if (any) observe(got);
            if (rsp_valid) observe({K_RSP, 20'h0, rsp_rdata});
        end
    end

    // Drive one request, wait for acceptance, and queue the events the spec predicts.
    task automatic send(input bit w, input bit bg, input logic [1:0] bk, input logic [16:0] row,
                        input logic [9:0] col, input logic [15:0] d, output int n);
        logic [2:0]  b;
        logic [19:0] ba;
        int t, k;
        b = {bg, bk};
        ba = {b, 17'h0};
        req_valid = 1'b1; req_write = w; req_bg = bg; req_bank = bk;
        req_row = row; req_col = col; req_wdata = d;
        k = 0;
        while (!req_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) chk("accept_timeout", 64'd1, 64'd0);
        n = cyc;
        t = n + 1;
        if (!(mvld[b] && mrow[b] == row)) begin
            if (mvld[b]) begin
                push(t, K_PRE, 20'h08000 | ba, 16'h0);
                t += 4;
            end
            push(t, K_ACT, {b, row}, 16'h0);
            mvld[b] = 1'b1;
            mrow[b] = row;
            t += 4;
        end
        if (w) begin
            push(t, K_WR, 20'h10000 | ba | 20'(col), d);
        end else begin
            push(t, K_RD, 20'h14000 | ba | 20'(col), 16'h0);
            rd_cyc = t + 4;
            rd_dat = d;
            push(t + 4, K_RSP, 20'h0, d);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_act_n"},   64'(act_n),     64'd1);
        chk({tag, "_refresh"}, 64'(refresh),   64'd0);
        chk({tag, "_addr"},    64'(addr),      64'h1C000);
        chk({tag, "_data_in"}, 64'(data_in),   64'd0);
        chk({tag, "_ready"},   64'(req_ready), 64'd0);
        chk({tag, "_rsp_v"},   64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_d"},   64'(rsp_rdata), 64'd0);
    endtask

    initial begin
        int n, rel;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_bg = 1'b0; req_bank = '0;
        req_row = '0; req_col = '0; req_wdata = '0;
        for (int i = 0; i < 8; i++) begin mvld[i] = 1'b0; mrow[i] = '0; end

        // 1: reset for 3 cycles, ready one cycle after release
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst = 1'b0;
        rel = cyc;
        #1 chk("ready_at_release", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("ready_after_release", 64'(req_ready), 64'd1);

        // 2: write to closed bank -> ACT then WR
        send(1'b1, 1'b0, 2'd0, 17'd2, 10'd0, 16'hff00, n);
        // 3: read row hit -> RD next cycle, response T_CL later
        send(1'b0, 1'b0, 2'd0, 17'd2, 10'd0, 16'hff00, n);
        repeat (8) @(negedge clk);
        chk("data_in_hold", 64'(data_in), 64'hff00);
        // 4: row miss on bg1/bank3 -> PRE, ACT, WR; then a hit read
        send(1'b1, 1'b1, 2'd3, 17'd0, 10'd5, 16'h1234, n);
        send(1'b1, 1'b1, 2'd3, 17'd5, 10'd9, 16'habcd, n);
        send(1'b0, 1'b1, 2'd3, 17'd5, 10'h3ff, 16'h5a5a, n);
        repeat (8) @(negedge clk);

        // 5: refresh pending wins over a waiting request
        while (cyc < rel + 780) @(negedge clk);
        chk("ready_refresh_pending", 64'(req_ready), 64'd0);
        push(rel + 781, K_PREA, 20'h08400, 16'h0);
        push(rel + 785, K_REF, NOP, 16'h0);
        for (int i = 0; i < 8; i++) mvld[i] = 1'b0;
        send(1'b1, 1'b0, 2'd0, 17'd2, 10'd3, 16'h7777, n);
        chk("accept_after_refresh", 64'(n), 64'(rel + 801));
        repeat (8) @(negedge clk);

        // 6: reset during ACT_W drops the request and empties the table
        send(1'b0, 1'b0, 2'd1, 17'd7, 10'd4, 16'h4321, n);
        @(negedge clk);
        rst = 1'b1;
        #1 chk_reset_outputs("midrst");
        sb.delete();
        rd_cyc = -1;
        for (int i = 0; i < 8; i++) mvld[i] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(1'b0, 1'b0, 2'd1, 17'd7, 10'd4, 16'h4321, n);
        repeat (12) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
